sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of serial bits per word; legal range 2..16.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-004 Port: start  input  1  request to begin capturing one word; sampled only in IDLE.
REQ-005 Port: d  input  1  serial data from the upstream D-latch stage, MSB first.
REQ-006 Port: q  output  WIDTH  last completed parallel word.
REQ-007 Port: valid  output  1  one-cycle pulse; q holds a newly completed word.
REQ-008 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-010 IDLE -> SHIFT on a rising edge with start=1. Otherwise IDLE is held.
REQ-011 In SHIFT, each rising edge SHALL shift d into the internal shift register LSB-side: sr <= {sr[WIDTH-2:0], d}. The bit counter SHALL also increment.
REQ-012 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL be 0 on entry to SHIFT.
REQ-013 SHIFT -> DONE on the edge that samples the WIDTH-th bit. On that same edge, q SHALL load the complete word (that final bit in q[0]) and the counter SHALL return to 0.
REQ-014 DONE -> IDLE unconditionally on the next rising edge.
REQ-015 valid SHALL be 1 only in DONE, giving exactly one clock-cycle pulse per word.
REQ-016 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-017 Timing: with start=1 at edge k, bits are sampled at edges k+1..k+WIDTH. valid is high between edges k+WIDTH and k+WIDTH+1. busy is low again after edge k+WIDTH+1.
REQ-018 start SHALL be ignored in SHIFT and DONE. There is no queuing, and the minimum start-to-start spacing is WIDTH+2 cycles.
REQ-019 start held continuously high SHALL restart capture on the first edge after the return to IDLE.
REQ-020 q SHALL hold its value until the next completed word, and SHALL NOT change during SHIFT.
REQ-021 The partial contents of sr SHALL never be visible on q.

Reset
REQ-022 Reset asserted SHALL force state=IDLE, sr=0, counter=0, q=0, valid=0 and busy=0 asynchronously.
REQ-023 Reset asserted mid-SHIFT or in DONE SHALL discard the partial word; no valid pulse SHALL follow.
REQ-024 After reset deasserts, the first start SHALL be honoured on the first rising edge at which it is sampled.

Structure
REQ-025 A shared package SHALL hold the state encoding constants (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the WIDTH default.
REQ-026 A single sub-module d_ff_async SHALL be used: a 1-bit D flip-flop with asynchronous active-high reset.
REQ-027 d_ff_async SHALL be instantiated per shift-register bit and per state bit; q, valid and busy SHALL be decoded from the state.
REQ-028 The design SHALL contain no latches and no combinational feedback loops.

Verification
REQ-029 Basic capture: reset, then start=1 for one cycle and d serial 1,0,1,1,0,0,1,0 -> q=8'hB2 and a single valid pulse at edge k+8; busy high for 9 cycles.
REQ-030 Ignored start: pulse start=1 during SHIFT at bit 3 and again in DONE -> no effect on sampling, exactly one valid pulse, q as in REQ-029.
REQ-031 Reset mid-word: assert reset after 5 of 8 bits -> q=0, valid=0 and busy=0 immediately; no later valid pulse without a new start.
REQ-032 Back-to-back words: start held high, words 8'hFF then 8'h01 -> two valid pulses exactly 10 cycles apart, q=8'hFF then q=8'h01.
REQ-033 Width boundary: WIDTH=2, d=1,0 -> q=2'b10 with valid at edge k+2; WIDTH=16, word 16'hA5C3 -> valid at edge k+16.
REQ-034 Hold check: after a word completes, toggle d randomly in IDLE for 20 cycles -> q unchanged and valid stays 0.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer:
// FSM state encoding and the default word width.
package sipo_deserializer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Handshake and data bundle between the serial source and the deserializer.
// master drives start/d; slave (the deserializer) returns q/valid/busy.
interface sipo_deserializer_if
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic             d;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             busy;

  modport master (output start, output d, input q, input valid, input busy);
  modport slave  (input start, input d, output q, output valid, output busy);

endinterface

// File: rtl/sipo_deserializer_d_ff_async.sv
// Single-bit D flip-flop with asynchronous active-high clear; the storage
// primitive for the deserializer's state and shift-register bits.
module d_ff_async (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  // NOTE: edge-triggered state always uses non-blocking (<=) so every flop
  // samples pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Captures WIDTH serial bits (MSB first) after a start request and presents
// the finished word on q with a one-cycle valid pulse.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  sipo_deserializer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  // The WIDTH-th bit goes straight into the output word, so the shift
  // register only has to hold the first WIDTH-1 bits.
  localparam int SR_W  = WIDTH - 1;

  state_t           state_q, state_d;
  logic [1:0]       state_bits_q, state_bits_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             shift_en;

  // ---------------- state register ----------------
  assign state_bits_d = state_d;
  assign state_q      = state_t'(state_bits_q);

  for (genvar i = 0; i < 2; i++) begin : g_state_ff
    d_ff_async u_ff (
      .clock (clock),
      .reset (reset),
      .d     (state_bits_d[i]),
      .q     (state_bits_q[i])
    );
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    shift_en  = (state_q == SHIFT);
    bus.valid = (state_q == DONE);
    bus.busy  = (state_q != IDLE);
  end

  // ---------------- datapath ----------------
  assign shifted  = {sr_q, bus.d};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (shift_en) begin
      sr_d = shifted[SR_W-1:0];
      if (last_bit) begin
        cnt_d = '0;
        out_d = shifted;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < SR_W; i++) begin : g_sr_ff
    d_ff_async u_ff (
      .clock (clock),
      .reset (reset),
      .d     (sr_d[i]),
      .q     (sr_q[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign bus.q = out_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer at WIDTH 8, 2 and 16, checked every
// cycle against an edge-counting model plus literal word/timing expectations.
module tb_sipo_deserializer;

  localparam int WID [3] = '{8, 2, 16};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic start_v [3] = '{1'b0, 1'b0, 1'b0};
  logic d_v     [3] = '{1'b0, 1'b0, 1'b0};

  sipo_deserializer_if #(.WIDTH(8))  if8  ();
  sipo_deserializer_if #(.WIDTH(2))  if2  ();
  sipo_deserializer_if #(.WIDTH(16)) if16 ();

  assign if8.start  = start_v[0];
  assign if8.d      = d_v[0];
  assign if2.start  = start_v[1];
  assign if2.d      = d_v[1];
  assign if16.start = start_v[2];
  assign if16.d     = d_v[2];

  sipo_deserializer #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(if8.slave));
  sipo_deserializer #(.WIDTH(2))  dut2  (.clock(clock), .reset(reset), .bus(if2.slave));
  sipo_deserializer #(.WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(if16.slave));

  logic [15:0] q_a     [3];
  logic        valid_a [3];
  logic        busy_a  [3];

  assign q_a[0] = 16'(if8.q);
  assign q_a[1] = 16'(if2.q);
  assign q_a[2] = if16.q;
  assign valid_a[0] = if8.valid;
  assign valid_a[1] = if2.valid;
  assign valid_a[2] = if16.valid;
  assign busy_a[0]  = if8.busy;
  assign busy_a[1]  = if2.busy;
  assign busy_a[2]  = if16.busy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase counts edges since start was accepted (-1 = idle).
  // Bits arrive at phases 1..W, the word is complete at phase W (valid),
  // and the block is free again one edge later.
  int          phase      [3] = '{-1, -1, -1};
  int          bits       [3] = '{0, 0, 0};
  logic [15:0] word       [3] = '{16'h0, 16'h0, 16'h0};
  int          accept_cyc [3] = '{0, 0, 0};
  int          cyc = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        phase[i] <= -1;
        bits[i]  <= 0;
        word[i]  <= 16'h0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
        if (phase[i] < 0) begin
          if (start_v[i]) begin
            phase[i]      <= 0;
            bits[i]       <= 0;
            accept_cyc[i] <= cyc + 1;
          end
        end else if (phase[i] < WID[i]) begin
          bits[i]  <= (bits[i] << 1) | int'(d_v[i]);
          phase[i] <= phase[i] + 1;
          if (phase[i] + 1 == WID[i])
            word[i] <= 16'(((bits[i] << 1) | int'(d_v[i])) & ((1 << WID[i]) - 1));
        end else begin
          phase[i] <= -1;
        end
      end
    end
  end

  // Per-cycle comparison plus pulse bookkeeping for the literal checks.
  int          pulse_cnt [3] = '{0, 0, 0};
  int          busy_cnt  [3] = '{0, 0, 0};
  int          last_vc   [3] = '{0, 0, 0};
  int          prev_vc   [3] = '{0, 0, 0};
  logic [15:0] last_word [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] prev_word [3] = '{16'h0, 16'h0, 16'h0};

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("valid[w%0d]", WID[i]), 32'(valid_a[i]), 32'(phase[i] == WID[i]));
      check($sformatf("busy[w%0d]",  WID[i]), 32'(busy_a[i]),  32'(phase[i] >= 0));
      check($sformatf("q[w%0d]",     WID[i]), 32'(q_a[i]),     32'(word[i]));
      if (valid_a[i]) begin
        pulse_cnt[i] <= pulse_cnt[i] + 1;
        prev_vc[i]   <= last_vc[i];
        last_vc[i]   <= cyc;
        prev_word[i] <= last_word[i];
        last_word[i] <= q_a[i];
      end
      if (busy_a[i]) busy_cnt[i] <= busy_cnt[i] + 1;
    end
  end

  task automatic step(input int i, input logic s, input logic dd);
    @(posedge clock);
    #2;
    start_v[i] = s;
    d_v[i]     = dd;
  endtask

  task automatic send_bits(input int i, input int w, input logic [15:0] val, input logic hold_start);
    for (int b = w - 1; b >= 0; b--) step(i, hold_start, val[b]);
  endtask

  task automatic idle(input int i, input int n);
    for (int k = 0; k < n; k++) step(i, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  int base_p, base_b;

  initial begin
    // Reset state while reset is held from time zero.
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_q[w%0d]", WID[i]),     32'(q_a[i]),     32'h0);
      check($sformatf("rst_valid[w%0d]", WID[i]), 32'(valid_a[i]), 32'h0);
      check($sformatf("rst_busy[w%0d]", WID[i]),  32'(busy_a[i]),  32'h0);
    end
    idle(0, 2);
    reset = 1'b0;
    idle(0, 2);

    // Basic capture of 8'hB2.
    base_p = pulse_cnt[0];
    base_b = busy_cnt[0];
    step(0, 1'b1, 1'b0);
    send_bits(0, 8, 16'h00B2, 1'b0);
    idle(0, 3);
    settle();
    check("basic_q",       32'(q_a[0]), 32'h00B2);
    check("basic_pulses",  32'(pulse_cnt[0] - base_p), 32'd1);
    check("basic_busy",    32'(busy_cnt[0] - base_b), 32'd9);
    check("basic_latency", 32'(last_vc[0] - accept_cyc[0]), 32'd8);

    // start pulsed during SHIFT (3rd bit) and again in DONE is ignored.
    base_p = pulse_cnt[0];
    base_b = busy_cnt[0];
    step(0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      logic [7:0] w8;
      w8 = 8'hB2;
      step(0, (n == 2), w8[7-n]);
    end
    step(0, 1'b1, 1'b0);
    idle(0, 3);
    settle();
    check("ign_q",      32'(q_a[0]), 32'h00B2);
    check("ign_pulses", 32'(pulse_cnt[0] - base_p), 32'd1);
    check("ign_busy",   32'(busy_cnt[0] - base_b), 32'd9);

    // Reset after 5 of 8 bits discards the partial word.
    step(0, 1'b1, 1'b0);
    send_bits(0, 5, 16'h0016, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_q",     32'(q_a[0]),     32'h0);
    check("midrst_valid", 32'(valid_a[0]), 32'h0);
    check("midrst_busy",  32'(busy_a[0]),  32'h0);
    idle(0, 2);
    reset = 1'b0;
    base_p = pulse_cnt[0];
    idle(0, 12);
    settle();
    check("midrst_no_pulse", 32'(pulse_cnt[0] - base_p), 32'd0);
    check("midrst_q_after",  32'(q_a[0]), 32'h0);

    // Back-to-back words with start held high: 8'hFF then 8'h01.
    base_p = pulse_cnt[0];
    step(0, 1'b1, 1'b0);
    send_bits(0, 8, 16'h00FF, 1'b1);
    step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0);
    send_bits(0, 8, 16'h0001, 1'b0);
    idle(0, 3);
    settle();
    check("b2b_pulses",  32'(pulse_cnt[0] - base_p), 32'd2);
    check("b2b_word0",   32'(prev_word[0]), 32'h00FF);
    check("b2b_word1",   32'(last_word[0]), 32'h0001);
    check("b2b_spacing", 32'(last_vc[0] - prev_vc[0]), 32'd10);

    // Width boundaries: WIDTH=2 with d=1,0 and WIDTH=16 with 16'hA5C3.
    base_p = pulse_cnt[1];
    step(1, 1'b1, 1'b0);
    send_bits(1, 2, 16'h0002, 1'b0);
    idle(1, 3);
    settle();
    check("w2_q",       32'(q_a[1]), 32'h0002);
    check("w2_pulses",  32'(pulse_cnt[1] - base_p), 32'd1);
    check("w2_latency", 32'(last_vc[1] - accept_cyc[1]), 32'd2);

    base_p = pulse_cnt[2];
    step(2, 1'b1, 1'b0);
    send_bits(2, 16, 16'hA5C3, 1'b0);
    idle(2, 3);
    settle();
    check("w16_q",       32'(q_a[2]), 32'hA5C3);
    check("w16_pulses",  32'(pulse_cnt[2] - base_p), 32'd1);
    check("w16_latency", 32'(last_vc[2] - accept_cyc[2]), 32'd16);

    // Hold: random d in IDLE must not disturb q or raise valid.
    base_p = pulse_cnt[0];
    base_b = busy_cnt[0];
    for (int k = 0; k < 20; k++) step(0, 1'b0, 1'($urandom_range(0, 1)));
    idle(0, 1);
    settle();
    check("hold_q",      32'(q_a[0]), 32'h0001);
    check("hold_pulses", 32'(pulse_cnt[0] - base_p), 32'd0);
    check("hold_busy",   32'(busy_cnt[0] - base_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
